frame_buffer_reader: RTL and testbench
======================================

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd0, custom-instruction number it answers.
REQ-002 SHALL have parameter fifoDepth, default 32, number of 32-bit words in the output FIFO (power of 2, at least 16).
REQ-003 clock  in  1  single system clock; reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 ciStart, ciCke  in  1 each  custom-instruction start and clock enable.
REQ-006 ciN  in  8  custom-instruction number.
REQ-007 ciValueA, ciValueB  in  32 each  command select and operand.
REQ-008 ciResult  out  32  result; zero when not selected.
REQ-009 ciDone  out  1  command done.
REQ-010 requestBus  out  1  bus request.
REQ-011 busGrant  in  1  bus grant.
REQ-012 beginTransactionOut, endTransactionOut  out  1 each  transaction framing.
REQ-013 readNotWriteOut  out  1  transaction direction.
REQ-014 byteEnablesOut  out  4  byte enables.
REQ-015 burstSizeOut  out  8  burst length minus 1.
REQ-016 addressDataOut  out  32  address phase.
REQ-017 addressDataIn  in  32  read data.
REQ-018 dataValidIn, endTransactionIn, busyIn, busErrorIn  in  1 each  responder signals.
REQ-019 pixelRead  in  1  consumer pops one word.
REQ-020 pixelData  out  32  FIFO head word.
REQ-021 pixelEmpty  out  1  FIFO empty.

Function
REQ-022 A command SHALL be selected when ciN equals customInstructionId and ciStart and ciCke are both 1; ciDone SHALL be asserted combinationally in that same cycle.
REQ-023 The command with ciValueA[3:0] set to 0 SHALL return the base address; set to 1 SHALL write base = {ciValueB[31:2],2'b00}; set to 2 SHALL write wordCount = ciValueB[19:0]; set to 3 SHALL start a frame read when ciValueB[0] is 1 and no frame read is running, and SHALL otherwise be ignored; set to 4 SHALL return {29'd0,error,running,done} and clear done and error on the following edge; any other value SHALL return 0.
REQ-024 Starting a frame read SHALL load the address register from base and the remaining-word count from wordCount, flush the FIFO, and set running; a wordCount of 0 SHALL set done immediately.
REQ-025 The FSM SHALL have the states IDLE, REQUEST_BUS, INIT_BURST, RECEIVE, ERROR.
REQ-026 IDLE SHALL move to REQUEST_BUS when running is set, the remaining count is non-zero, and FIFO free space is at least 16.
REQ-027 REQUEST_BUS SHALL assert requestBus combinationally and move to INIT_BURST on busGrant.
REQ-028 In INIT_BURST the burst length n SHALL be min(16, remaining), and the next edge SHALL register beginTransactionOut=1, readNotWriteOut=1, byteEnablesOut=4'hF, burstSizeOut=n-1 and addressDataOut=address for exactly one cycle; these outputs SHALL be 0 at all other times.
REQ-029 In RECEIVE, each cycle with dataValidIn=1 SHALL push addressDataIn into the FIFO, advance the address by 4, and decrement the remaining count.
REQ-030 RECEIVE SHALL move to IDLE on endTransactionIn.
REQ-031 When the remaining count reaches 0, running SHALL clear and done SHALL set.
REQ-032 busErrorIn in RECEIVE SHALL move to ERROR; ERROR SHALL register endTransactionOut=1 for one cycle, set error, clear running, and return to IDLE; the FIFO contents SHALL be kept.
REQ-033 dataValidIn outside RECEIVE SHALL be ignored; a push to a full FIFO SHALL be dropped and SHALL set error.
REQ-034 pixelRead while pixelEmpty is 1 SHALL be ignored; when a push and a pop occur in the same cycle, the occupancy SHALL be unchanged.
REQ-035 pixelData SHALL show the head word combinationally (first-word fall-through).
REQ-036 The address SHALL wrap modulo 2^32; the remaining count SHALL be 20 bits wide.
REQ-037 The start command SHALL be ignored while running is set.

Reset
REQ-038 Reset SHALL put the FSM in IDLE and clear base, wordCount, address, running, done, error and the FIFO pointers.
REQ-039 Reset SHALL drive every bus output to 0 on the next edge, including mid-burst, without issuing endTransactionOut.

Structure
REQ-040 The FSM state encodings, the command codes 0-4, and the maximum burst length of 16 SHALL be placed in a shared package.
REQ-041 The FIFO SHALL be a sub-module named sync_word_fifo (single clock; push, pop, full, empty, free count).

Verification
REQ-042 Scenario: base=0x1000, wordCount=40, start -> bursts of 16, 16, 8 at addresses 0x1000, 0x1040, 0x1080; burstSizeOut 15, 15, 7; status reads 3'b001.
REQ-043 Scenario: consumer stalled, wordCount=64, fifoDepth=32 -> after 32 words no new requestBus until at least 16 pops.
REQ-044 Scenario: busErrorIn on the 3rd data beat -> endTransactionOut for one cycle, status reads 3'b100, two words remain in the FIFO.
REQ-045 Scenario: push and pop in the same cycle with the FIFO holding 5 words -> occupancy stays 5 and pixelData advances correctly.
REQ-046 Scenario: reset during RECEIVE -> all bus outputs 0 on the next edge, pixelEmpty=1, status reads 0.
REQ-047 Scenario: start with wordCount=0 -> no requestBus, status reads 3'b001; a second status read returns 0.

Source files
------------

// File: rtl/frame_buffer_reader_pkg.sv
// Shared types and constants for the frame buffer reader: FSM states, custom-instruction
// command codes, status layout and the burst-length rule.
package frame_buffer_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST_BUS,
        INIT_BURST,
        RECEIVE,
        ERROR
    } state_e;

    typedef enum logic [3:0] {
        CMD_GET_BASE  = 4'd0,
        CMD_SET_BASE  = 4'd1,
        CMD_SET_COUNT = 4'd2,
        CMD_START     = 4'd3,
        CMD_STATUS    = 4'd4
    } cmd_e;

    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned COUNT_W   = 20;

    // Bit order matches the status word returned to software: {error, running, done}.
    typedef struct packed {
        logic error;
        logic running;
        logic done;
    } status_t;

    function automatic logic [7:0] burst_len(input logic [COUNT_W-1:0] remaining);
        return (remaining >= COUNT_W'(MAX_BURST)) ? 8'(MAX_BURST) : remaining[7:0];
    endfunction

endpackage

// File: rtl/frame_buffer_reader_if.sv
// Bus-side signals of the frame buffer reader; the reader is the master, the memory
// responder/arbiter is the slave.
interface frame_buffer_reader_if;

    logic        requestBus;
    logic        busGrant;
    logic        beginTransactionOut;
    logic        endTransactionOut;
    logic        readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busyIn;
    logic        busErrorIn;

    modport master (
        output requestBus, beginTransactionOut, endTransactionOut, readNotWriteOut,
               byteEnablesOut, burstSizeOut, addressDataOut,
        input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busyIn, busErrorIn
    );

    modport slave (
        input  requestBus, beginTransactionOut, endTransactionOut, readNotWriteOut,
               byteEnablesOut, burstSizeOut, addressDataOut,
        output busGrant, addressDataIn, dataValidIn, endTransactionIn, busyIn, busErrorIn
    );

endinterface

// File: rtl/frame_buffer_reader_fifo.sv
// Single-clock first-word-fall-through word FIFO with flush and free-space count.
module sync_word_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign free_o  = (AW+1)'(DEPTH) - count;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses <= so every flop samples pre-edge values of its peers.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are valid, so the
    // array stays free to map onto RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Custom-instruction controlled frame reader: bursts words from memory into a FIFO
// that a pixel consumer drains.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned fifoDepth           = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ciStart,
    input  logic                  ciCke,
    input  logic [7:0]            ciN,
    input  logic [31:0]           ciValueA,
    input  logic [31:0]           ciValueB,
    output logic [31:0]           ciResult,
    output logic                  ciDone,
    frame_buffer_reader_if.master bus,
    input  logic                  pixelRead,
    output logic [31:0]           pixelData,
    output logic                  pixelEmpty
);

    localparam int unsigned FREE_W = $clog2(fifoDepth) + 1;

    state_e             state_q;
    logic [31:0]        base_q, base_d;
    logic [31:0]        address_q, address_d;
    logic [COUNT_W-1:0] word_count_q, word_count_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    status_t            status_q, status_d;

    logic               begin_q, end_q, rnw_q;
    logic [3:0]         be_q;
    logic [7:0]         burst_q;
    logic [31:0]        addr_out_q;

    logic               selected, start_frame, status_read, beat;
    logic [3:0]         cmd;
    logic               fifo_full;
    logic [FREE_W-1:0]  fifo_free;
    logic               unused_inputs;

    assign unused_inputs = ^{bus.busyIn, ciValueA[31:4]};

    assign selected    = ciStart && ciCke && (ciN == customInstructionId);
    assign cmd         = ciValueA[3:0];
    assign ciDone      = selected;
    assign start_frame = selected && (cmd == CMD_START) && ciValueB[0] && !status_q.running;
    assign status_read = selected && (cmd == CMD_STATUS);
    // A beat flagged with a bus error carries no valid data; beats past the frame end are dropped.
    assign beat = (state_q == RECEIVE) && bus.dataValidIn && !bus.busErrorIn &&
                  (remaining_q != '0);

    always_comb begin
        ciResult = '0;
        if (selected) begin
            case (cmd)
                CMD_GET_BASE: ciResult = base_q;
                CMD_STATUS:   ciResult = {29'd0, status_q};
                default:      ciResult = '0;
            endcase
        end
    end

    assign bus.requestBus          = (state_q == REQUEST_BUS);
    assign bus.beginTransactionOut = begin_q;
    assign bus.endTransactionOut   = end_q;
    assign bus.readNotWriteOut     = rnw_q;
    assign bus.byteEnablesOut      = be_q;
    assign bus.burstSizeOut        = burst_q;
    assign bus.addressDataOut      = addr_out_q;

    // NOTE: every _d is given its hold value first, so no path through this block infers a latch.
    always_comb begin
        base_d       = base_q;
        word_count_d = word_count_q;
        address_d    = address_q;
        remaining_d  = remaining_q;
        status_d     = status_q;

        if (selected && cmd == CMD_SET_BASE)  base_d       = {ciValueB[31:2], 2'b00};
        if (selected && cmd == CMD_SET_COUNT) word_count_d = ciValueB[COUNT_W-1:0];

        // Events later in this block override the read-to-clear so none are lost.
        if (status_read) begin
            status_d.done  = 1'b0;
            status_d.error = 1'b0;
        end

        if (beat) begin
            address_d   = address_q + 32'd4;
            remaining_d = remaining_q - 1'b1;
            if (fifo_full) status_d.error = 1'b1;
            if (remaining_q == COUNT_W'(1)) begin
                status_d.running = 1'b0;
                status_d.done    = 1'b1;
            end
        end

        if (state_q == ERROR) begin
            status_d.error   = 1'b1;
            status_d.running = 1'b0;
        end

        if (start_frame) begin
            address_d        = base_q;
            remaining_d      = word_count_q;
            status_d.running = (word_count_q != '0);
            status_d.done    = (word_count_q == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q       <= '0;
            word_count_q <= '0;
            address_q    <= '0;
            remaining_q  <= '0;
            status_q     <= '0;
        end else begin
            base_q       <= base_d;
            word_count_q <= word_count_d;
            address_q    <= address_d;
            remaining_q  <= remaining_d;
            status_q     <= status_d;
        end
    end

    // Bus framing outputs default to 0 every cycle and pulse only from INIT_BURST / ERROR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            begin_q    <= 1'b0;
            end_q      <= 1'b0;
            rnw_q      <= 1'b0;
            be_q       <= '0;
            burst_q    <= '0;
            addr_out_q <= '0;
        end else begin
            begin_q    <= 1'b0;
            end_q      <= 1'b0;
            rnw_q      <= 1'b0;
            be_q       <= '0;
            burst_q    <= '0;
            addr_out_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (status_q.running && remaining_q != '0 &&
                        fifo_free >= FREE_W'(MAX_BURST))
                        state_q <= REQUEST_BUS;
                end
                REQUEST_BUS: begin
                    if (bus.busGrant) state_q <= INIT_BURST;
                end
                INIT_BURST: begin
                    begin_q    <= 1'b1;
                    rnw_q      <= 1'b1;
                    be_q       <= 4'hF;
                    burst_q    <= burst_len(remaining_q) - 8'd1;
                    addr_out_q <= address_q;
                    state_q    <= RECEIVE;
                end
                RECEIVE: begin
                    if (bus.busErrorIn)            state_q <= ERROR;
                    else if (bus.endTransactionIn) state_q <= IDLE;
                end
                ERROR: begin
                    end_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_word_fifo #(
        .DEPTH (fifoDepth),
        .WIDTH (32)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (start_frame),
        .push_i      (beat),
        .push_data_i (bus.addressDataIn),
        .pop_i       (pixelRead),
        .head_o      (pixelData),
        .full_o      (fifo_full),
        .empty_o     (pixelEmpty),
        .free_o      (fifo_free)
    );

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed/randomised bench for frame_buffer_reader with a queue-based reference model
// of the frame, the FIFO contents and the status flags.
module tb_frame_buffer_reader;

    localparam logic [7:0] CI_ID = 8'h2A;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart, ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB, ciResult;
    logic        ciDone;
    logic        pixelRead;
    logic [31:0] pixelData;
    logic        pixelEmpty;

    frame_buffer_reader_if bus_if();

    frame_buffer_reader #(
        .customInstructionId (CI_ID),
        .fifoDepth           (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ciStart    (ciStart),
        .ciCke      (ciCke),
        .ciN        (ciN),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciResult   (ciResult),
        .ciDone     (ciDone),
        .bus        (bus_if),
        .pixelRead  (pixelRead),
        .pixelData  (pixelData),
        .pixelEmpty (pixelEmpty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: software-visible registers, frame progress and FIFO contents.
    logic [31:0] m_q[$];
    logic [31:0] m_base, m_addr;
    int          m_count, m_rem;
    bit          m_run, m_done, m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] bus_outs();
        return {bus_if.requestBus, bus_if.beginTransactionOut, bus_if.endTransactionOut,
                bus_if.readNotWriteOut, bus_if.byteEnablesOut, bus_if.burstSizeOut,
                bus_if.addressDataOut};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_base = 0; m_addr = 0; m_count = 0; m_rem = 0;
        m_run = 0; m_done = 0; m_err = 0;
    endtask

    task automatic ci_cmd(input logic [3:0] code, input logic [31:0] b, output logic [31:0] res);
        @(negedge clock);
        ciStart = 1'b1; ciCke = 1'b1; ciN = CI_ID;
        ciValueA = {28'd0, code}; ciValueB = b;
        #1;
        check("ci_done", ciDone, 1'b1);
        res = ciResult;
        @(negedge clock);
        ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0; ciValueB = '0;
    endtask

    task automatic set_base(input logic [31:0] b);
        logic [31:0] r;
        ci_cmd(4'd1, b, r);
        m_base = {b[31:2], 2'b00};
    endtask

    task automatic set_count(input int c);
        logic [31:0] r;
        ci_cmd(4'd2, 32'(c), r);
        m_count = c;
    endtask

    task automatic start_frame(input logic [31:0] b);
        logic [31:0] r;
        ci_cmd(4'd3, b, r);
        if (b[0] && !m_run) begin
            m_q.delete();
            m_addr = m_base;
            m_rem  = m_count;
            m_run  = (m_count != 0);
            m_done = (m_count == 0);
        end
    endtask

    task automatic status_check(input string tag);
        logic [31:0] r;
        logic [31:0] exp;
        exp = {29'd0, m_err, m_run, m_done};
        ci_cmd(4'd4, 32'd0, r);
        check(tag, r, exp);
        m_err = 0; m_done = 0;
    endtask

    task automatic wait_request(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus_if.requestBus) begin
                ok = 1;
                break;
            end
        end
        check("request_seen", ok, 1'b1);
    endtask

    task automatic no_request(input string tag, input int cycles);
        bit seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (bus_if.requestBus) seen = 1;
        end
        check(tag, seen, 1'b0);
    endtask

    task automatic pop_words(input int k);
        for (int i = 0; i < k; i++) begin
            check("pop_not_empty", pixelEmpty, 1'b0);
            if (m_q.size() > 0) begin
                check("pop_data", pixelData, m_q[0]);
                void'(m_q.pop_front());
            end
            pixelRead = 1'b1;
            @(negedge clock);
        end
        pixelRead = 1'b0;
    endtask

    // Acts as arbiter and memory for one burst. err_at: beat index that carries busErrorIn
    // (-1 none). pop_from: from this beat on, pop the consumer side in the same cycle (-1 none).
    task automatic serve_burst(input int err_at, input int pop_from);
        bit ok;
        int n;
        logic [31:0] data;
        wait_request(ok);
        if (!ok) return;
        n = (m_rem < 16) ? m_rem : 16;
        bus_if.busGrant = 1'b1;
        @(negedge clock);
        bus_if.busGrant = 1'b0;
        @(negedge clock);
        check("begin_pulse", bus_if.beginTransactionOut, 1'b1);
        check("read_dir", bus_if.readNotWriteOut, 1'b1);
        check("byte_en", bus_if.byteEnablesOut, 4'hF);
        check("burst_size", bus_if.burstSizeOut, 8'(n - 1));
        check("burst_addr", bus_if.addressDataOut, m_addr);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus_if.dataValidIn = 1'b0; pixelRead = 1'b0;
                @(negedge clock);
            end
            data = $urandom;
            bus_if.addressDataIn = data;
            bus_if.dataValidIn = 1'b1;
            if (i == err_at) begin
                bus_if.busErrorIn = 1'b1;
                pixelRead = 1'b0;
                @(negedge clock);
                bus_if.dataValidIn = 1'b0; bus_if.busErrorIn = 1'b0;
                @(negedge clock);
                check("err_end_pulse", bus_if.endTransactionOut, 1'b1);
                @(negedge clock);
                check("err_end_one_cycle", bus_if.endTransactionOut, 1'b0);
                m_err = 1; m_run = 0;
                return;
            end
            if (pop_from >= 0 && i >= pop_from) begin
                check("simul_head", pixelData, m_q[0]);
                void'(m_q.pop_front());
                pixelRead = 1'b1;
            end else begin
                pixelRead = 1'b0;
            end
            m_q.push_back(data);
            m_addr += 4;
            m_rem--;
            if (m_rem == 0) begin
                m_run = 0; m_done = 1;
            end
            @(negedge clock);
            if (i == 0) check("begin_one_cycle", bus_if.beginTransactionOut, 1'b0);
        end
        bus_if.dataValidIn = 1'b0; pixelRead = 1'b0;
        bus_if.endTransactionIn = 1'b1;
        @(negedge clock);
        bus_if.endTransactionIn = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit ok;
        reset = 1'b1;
        ciStart = 0; ciCke = 0; ciN = '0; ciValueA = '0; ciValueB = '0; pixelRead = 0;
        bus_if.busGrant = 0; bus_if.addressDataIn = '0; bus_if.dataValidIn = 0;
        bus_if.endTransactionIn = 0; bus_if.busyIn = 0; bus_if.busErrorIn = 0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state and selection logic.
        check("reset_bus_outs", bus_outs(), 48'd0);
        check("reset_empty", pixelEmpty, 1'b1);
        check("idle_no_done", ciDone, 1'b0);
        check("idle_result_zero", ciResult, 32'd0);
        status_check("reset_status");
        ci_cmd(4'd0, 32'd0, r);
        check("reset_base", r, 32'd0);
        @(negedge clock);
        ciStart = 1; ciCke = 1; ciN = CI_ID + 8'd1; ciValueA = 32'd4;
        #1;
        check("wrong_id_done", ciDone, 1'b0);
        check("wrong_id_result", ciResult, 32'd0);
        ciN = CI_ID; ciCke = 0;
        #1;
        check("no_cke_done", ciDone, 1'b0);
        ciStart = 0; ciValueA = '0;
        ci_cmd(4'd7, 32'hFFFF_FFFF, r);
        check("unknown_cmd_zero", r, 32'd0);

        // Three bursts of 16/16/8 from 0x1000.
        set_base(32'h0000_1003);
        ci_cmd(4'd0, 32'd0, r);
        check("base_readback", r, 32'h0000_1000);
        set_count(40);
        start_frame(32'd0);
        no_request("start_bit_clear", 10);
        start_frame(32'd1);
        serve_burst(-1, -1);
        pop_words(16);
        serve_burst(-1, -1);
        pop_words(16);
        serve_burst(-1, -1);
        pop_words(8);
        check("frame_drained", pixelEmpty, 1'b1);
        status_check("frame_done_status");
        status_check("status_cleared");

        // Zero-length frame; stray dataValid and pops while idle/empty are ignored.
        set_count(0);
        start_frame(32'd1);
        bus_if.dataValidIn = 1'b1; bus_if.addressDataIn = 32'hDEAD_BEEF; pixelRead = 1'b1;
        no_request("zero_count_no_request", 20);
        bus_if.dataValidIn = 1'b0; pixelRead = 1'b0;
        @(negedge clock);
        check("stray_valid_ignored", pixelEmpty, 1'b1);
        status_check("zero_count_status");
        status_check("zero_count_cleared");

        // Push and pop in the same cycle with five words held.
        set_base(32'h0000_4000);
        set_count(10);
        start_frame(32'd1);
        serve_burst(-1, 5);
        pop_words(5);
        check("simul_final_empty", pixelEmpty, 1'b1);
        status_check("simul_status");

        // Stalled consumer: no new burst until 16 words of space are free.
        set_base(32'hFFFF_FFC0);
        set_count(64);
        start_frame(32'd1);
        serve_burst(-1, -1);
        serve_burst(-1, -1);
        no_request("full_no_request", 30);
        start_frame(32'd1);
        pop_words(15);
        no_request("fifteen_free_no_request", 20);
        pop_words(1);
        serve_burst(-1, -1);
        pop_words(32);
        serve_burst(-1, -1);
        pop_words(16);
        check("stall_final_empty", pixelEmpty, 1'b1);
        status_check("stall_status");

        // Bus error on the third beat.
        set_base(32'h0000_8000);
        set_count(16);
        start_frame(32'd1);
        serve_burst(2, -1);
        status_check("error_status");
        no_request("error_no_retry", 10);
        pop_words(2);
        check("error_two_words", pixelEmpty, 1'b1);

        // Reset in the middle of a burst.
        set_base(32'h0000_2000);
        set_count(16);
        start_frame(32'd1);
        wait_request(ok);
        bus_if.busGrant = 1'b1;
        @(negedge clock);
        bus_if.busGrant = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            bus_if.dataValidIn = 1'b1; bus_if.addressDataIn = $urandom;
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_bus_outs", bus_outs(), 48'd0);
        check("reset_mid_empty", pixelEmpty, 1'b1);
        reset = 1'b0; bus_if.dataValidIn = 1'b0;
        model_reset();
        status_check("reset_mid_status");
        ci_cmd(4'd0, 32'd0, r);
        check("reset_mid_base", r, 32'd0);
        no_request("reset_mid_no_request", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
